// File: rtl/fetch_pkg.sv
// Shared constants for the instruction-fetch stage: FSM state codes, PC step and default reset PC.
// Fault checking in instr_fetch is compiled in with FETCH_FAULT_CHECK_EN.
package fetch_pkg;

  typedef logic [1:0] fetch_state_t;

  localparam fetch_state_t FILL = 2'd0;
  localparam fetch_state_t RUN  = 2'd1;
  localparam fetch_state_t HALT = 2'd2;

  localparam logic [31:0] PC_STEP          = 32'd4;
  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;

endpackage

// File: rtl/instr_fetch.sv
// Fetch stage in front of a synchronous-read instruction memory; pairs each returned word with its PC.
// Optional FETCH_FAULT_CHECK_EN halts on misaligned or out-of-range fetch addresses.
import fetch_pkg::*;

module instr_fetch #(
  parameter int          ADDRESS_WIDTH = 9,
  parameter int          DATA_WIDTH    = 32,
  parameter logic [31:0] RESET_PC      = RESET_PC_DEFAULT
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     stall,
  input  logic                     redirect_valid,
  input  logic [31:0]              redirect_target,
  output logic                     mem_rd_en,
  output logic [ADDRESS_WIDTH-1:0] mem_address,
  input  logic [DATA_WIDTH-1:0]    mem_dout,
  output logic                     instr_valid,
  output logic [DATA_WIDTH-1:0]    instr,
  output logic [31:0]              instr_pc,
  output logic                     fault
);

  logic [31:0]  pc_issue_q, pc_issue_d;
  logic [31:0]  pc_resp_q,  pc_resp_d;
  fetch_state_t state_q,    state_d;
  logic         fault_q,    fault_d;
  logic         issue_ok_s;

`ifdef FETCH_FAULT_CHECK_EN
  function automatic logic addr_fault_f(input logic [31:0] pc);
    addr_fault_f = (pc[1:0] != 2'b00) || ((pc >> (ADDRESS_WIDTH + 2)) != 32'd0);
  endfunction

  assign issue_ok_s = !addr_fault_f(pc_issue_q);
`else
  // Without the check, the word address simply wraps modulo memory size.
  assign issue_ok_s = 1'b1;
`endif

  assign mem_rd_en   = !rst && !stall && (state_q != HALT) && issue_ok_s;
  assign mem_address = pc_issue_q[ADDRESS_WIDTH+1:2];
  assign instr_valid = (state_q == RUN);
  assign instr_pc    = pc_resp_q;
  assign instr       = mem_dout;
  assign fault       = fault_q;

  // Next-state: redirect beats stall and HALT; an issue edge advances the PC pair.
  always_comb begin
    pc_issue_d = pc_issue_q;
    pc_resp_d  = pc_resp_q;
    state_d    = state_q;
    fault_d    = fault_q;
    if (redirect_valid) begin
      pc_issue_d = redirect_target;
      state_d    = FILL;
      fault_d    = 1'b0;
    end else if (stall || (state_q == HALT)) begin
      state_d    = state_q;
    end else if (!issue_ok_s) begin
      state_d    = HALT;
      fault_d    = 1'b1;
    end else begin
      pc_resp_d  = pc_issue_q;
      pc_issue_d = pc_issue_q + PC_STEP;
      state_d    = RUN;
    end
  end

  // State registers with asynchronous reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc_issue_q <= RESET_PC;
      pc_resp_q  <= 32'd0;
      state_q    <= FILL;
      fault_q    <= 1'b0;
    end else begin
      pc_issue_q <= pc_issue_d;
      pc_resp_q  <= pc_resp_d;
      state_q    <= state_d;
      fault_q    <= fault_d;
    end
  end

endmodule

// File: doc/instr_fetch.md
# instr_fetch

Instruction-fetch stage sitting directly upstream of the single-cycle MIPS instruction memory. Holds the program counter, drives the memory's word address and read enable, and pairs each synchronous-read result with its PC for the decode stage. Also handles downstream stall, branch/jump redirect and, optionally, fetch-address faults.

## Interface
- `ADDRESS_WIDTH`, 9: word-address width of instruction memory (512 words).
- `DATA_WIDTH`, 32: instruction width.
- `RESET_PC`, 32'h0000_0000: byte address fetched first after reset.

- `clk`  in  1: single clock, all state on rising edge.
- `rst`  in  1: asynchronous, active-high reset.
- `stall`  in  1: decode cannot accept; freeze fetch.
- `redirect_valid`  in  1: branch/jump taken; flush and refetch.
- `redirect_target`  in  32: byte address of new fetch stream.
- `mem_rd_en`  out  1: read enable to instruction memory.
- `mem_address`  out  ADDRESS_WIDTH: word address, `pc_issue[ADDRESS_WIDTH+1:2]`.
- `mem_dout`  in  DATA_WIDTH: memory data, valid the cycle after a read issue.
- `instr_valid`  out  1: `instr`/`instr_pc` carry a live instruction.
- `instr`  out  DATA_WIDTH: pass-through of `mem_dout`.
- `instr_pc`  out  32: byte PC of `instr`.
- `fault`  out  1: fetch address fault (see Configuration).

## Operation
- Registers: `pc_issue` (address being read), `pc_resp` (address of data on `mem_dout`), state.
- States: FILL (no valid response), RUN (response valid), HALT (fault, no fetch).
- `mem_rd_en = !rst && !stall && state != HALT`, combinational.
- Issue edge (`mem_rd_en`=1, no redirect): `pc_resp <= pc_issue`; `pc_issue <= pc_issue + 4` (mod 2^32); state -> RUN.
- Redirect (`redirect_valid`=1): `pc_issue <= redirect_target`; state -> FILL; in-flight sequential read discarded. Redirect has priority over `stall` and exits HALT.
- Stall (`stall`=1, no redirect): all registers hold; memory not read, so `mem_dout` and `instr` hold.
- `instr_valid = (state == RUN)`; `instr_pc = pc_resp`; `instr = mem_dout`.

## Timing
- Reset (async): `pc_issue=RESET_PC`, `pc_resp=0`, state FILL, `instr_valid=0`, `mem_rd_en=0`, `fault=0`. `instr` undefined until first read.
- First edge after reset release: read of `RESET_PC` issued; `instr_valid`=1 on the following cycle.
- Steady state: one instruction per cycle, fetch latency 1 cycle.
- Redirect asserted in cycle t: `instr_valid`=0 in t+1, target instruction valid in t+2 (one bubble).
- Stall in cycle t: outputs in t+1 identical to t.
- Simultaneous stall and redirect: redirect executed, stall ignored for that edge.

## Configuration
- `FETCH_FAULT_CHECK_EN` defined: before issuing, if `pc_issue[1:0]!=0` or `pc_issue[31:ADDRESS_WIDTH+2]!=0`, no read is issued; state -> HALT; `fault` -> 1 sticky; `instr_valid`=0. Only reset or redirect clears it (redirect clears `fault` and enters FILL).
- Undefined: `fault` tied 0, HALT unreachable; low two bits ignored, upper bits truncated, so the address wraps modulo memory size.

## Structure
- Package `fetch_pkg`: state enum (FILL, RUN, HALT), `PC_STEP`=4, default `RESET_PC`.
- Single module. No sub-module; the fault check is a local function under the macro.

## Test plan
- Memory preloaded 0x11111111, 0x22222222, 0x33333333 at words 0-2; release reset -> `instr_valid` first high the 2nd cycle after release; `instr_pc`/`instr` = 0/0x11111111, 4/0x22222222, 8/0x33333333 on consecutive cycles.
- Stall for 3 cycles while `instr_pc`=4 -> `mem_rd_en`=0, `instr_pc`=4, `instr`=0x22222222 held; resumes with 8.
- Redirect to 0x40 while `instr_pc`=4 -> one cycle `instr_valid`=0, then `instr_pc`=0x40 with `instr`=mem[16].
- Stall and redirect to 0x20 in the same cycle -> redirect taken, `instr_pc`=0x20 two cycles later.
- With `FETCH_FAULT_CHECK_EN`: redirect to 0x802, then to 0x800 -> each time `fault`=1, `mem_rd_en`=0; redirect to 0x10 -> `fault`=0, `instr_pc`=0x10 two cycles later. Without the macro, 0x800 fetches word 0.
- Assert `rst` mid-run between edges -> `instr_valid`=0, `mem_rd_en`=0, `fault`=0 immediately; refetch starts at `RESET_PC`.
